// File: rtl/exception_commit_reporter.sv
// Precise-exception initiator: keeps the oldest reported exception, raises it when
// it reaches the ROB head, and holds until the handler answers with recover.
module exception_commit_reporter #(
    parameter int PTR_W   = 4,
    parameter int CAUSE_W = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               report_valid,
    input  logic [PTR_W-1:0]   report_rob_idx,
    input  logic [CAUSE_W-1:0] report_cause,
    input  logic [31:0]        report_epc,
    input  logic               rob_head_valid,
    input  logic [PTR_W-1:0]   rob_head_ptr,
    input  logic               flush_valid,
    input  logic [PTR_W-1:0]   flush_rob_idx,
    input  logic               recover,
    output logic               exception_occurred,
    output logic [PTR_W-1:0]   exception_pc,
    output logic [CAUSE_W-1:0] exception_cause,
    output logic [31:0]        exception_epc,
    output logic               retire_block,
    output logic               timeout_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        RAISE,
        WAIT_RECOVER
    } state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   held_idx, held_idx_next;
    logic [CAUSE_W-1:0] held_cause, held_cause_next;
    logic [31:0]        held_epc, held_epc_next;
    logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
    logic               timeout_err_next;
    logic               exc_pulse_q;

    // Ages are distances from the ROB head; modular subtraction handles index wrap.
    logic [PTR_W-1:0]   age_report, age_flush, age_held;
    logic               report_survives, held_flushed, head_match;

    assign age_report      = report_rob_idx - rob_head_ptr;
    assign age_flush       = flush_rob_idx - rob_head_ptr;
    assign age_held        = held_idx - rob_head_ptr;
    assign report_survives = report_valid && (!flush_valid || (age_report < age_flush));
    assign held_flushed    = flush_valid && (age_held >= age_flush);
    assign head_match      = rob_head_valid && (rob_head_ptr == held_idx);
    assign cnt_inc         = cnt + 1'b1;

    always_comb begin
        state_next       = state;
        held_idx_next    = held_idx;
        held_cause_next  = held_cause;
        held_epc_next    = held_epc;
        cnt_next         = cnt;
        timeout_err_next = timeout_err;

        case (state)
            IDLE: begin
                if (report_survives) begin
                    held_idx_next   = report_rob_idx;
                    held_cause_next = report_cause;
                    held_epc_next   = report_epc;
                    state_next      = PENDING;
                end
            end

            PENDING: begin
                // A flush covering the held entry wins over raising it this cycle.
                if (held_flushed) begin
                    if (report_survives) begin
                        held_idx_next   = report_rob_idx;
                        held_cause_next = report_cause;
                        held_epc_next   = report_epc;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (head_match) begin
                    state_next = RAISE;
                end else if (report_survives && (age_report < age_held)) begin
                    held_idx_next   = report_rob_idx;
                    held_cause_next = report_cause;
                    held_epc_next   = report_epc;
                end
            end

            RAISE: begin
                if (recover) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_RECOVER;
                    cnt_next   = '0;
                end
            end

            WAIT_RECOVER: begin
                if (recover) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        timeout_err_next = 1'b1;
                        state_next       = RAISE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            held_idx    <= '0;
            held_cause  <= '0;
            held_epc    <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
            exc_pulse_q <= 1'b0;
        end else begin
            state       <= state_next;
            held_idx    <= held_idx_next;
            held_cause  <= held_cause_next;
            held_epc    <= held_epc_next;
            cnt         <= cnt_next;
            timeout_err <= timeout_err_next;
            exc_pulse_q <= (state_next == RAISE);
        end
    end

    assign exception_occurred = exc_pulse_q;
    assign exception_pc       = (state != IDLE) ? held_idx   : '0;
    assign exception_cause    = (state != IDLE) ? held_cause : '0;
    assign exception_epc      = (state != IDLE) ? held_epc   : '0;
    assign retire_block       = ((state == PENDING) && head_match) ||
                                (state == RAISE) || (state == WAIT_RECOVER);

endmodule

// File: doc/exception_commit_reporter.md
# exception_commit_reporter

Initiator side of the precise-exception protocol. Collects exception reports from execution stages, tagged with ROB index, and keeps only the oldest one in program order. When that instruction reaches the ROB head, it blocks its retirement and issues a one-cycle `exception_occurred` request carrying the ROB index, cause and EPC. It then holds until the exception handler answers with `recover`. It sits between the execution and writeback stages, the ROB head, and the exception handler's `exception_occurred` / `exception_pc` / `recover` interface.

## Interface
- `PTR_W`, 4: ROB index width; ROB depth is 2^PTR_W.
- `CAUSE_W`, 4: exception cause code width.
- `TIMEOUT`, 15: cycles to wait for `recover` before re-raising the request.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-high.
- `report_valid` input 1: an exception report is present this cycle.
- `report_rob_idx` input PTR_W: ROB index of the faulting instruction.
- `report_cause` input CAUSE_W: cause code of the report.
- `report_epc` input 32: PC of the faulting instruction.
- `rob_head_valid` input 1: the ROB head entry is occupied.
- `rob_head_ptr` input PTR_W: ROB head index (oldest in-flight instruction).
- `flush_valid` input 1: mispredict flush this cycle.
- `flush_rob_idx` input PTR_W: first squashed ROB index; it and everything younger are squashed.
- `recover` input 1: acknowledge from the exception handler.
- `exception_occurred` output 1: registered one-cycle request pulse.
- `exception_pc` output PTR_W: ROB index of the raised exception; valid while not IDLE.
- `exception_cause` output CAUSE_W: cause of the held exception.
- `exception_epc` output 32: EPC of the held exception.
- `retire_block` output 1: combinational; forbids the ROB from committing its head.
- `timeout_err` output 1: sticky flag, set on any recover timeout; cleared only by reset.

## Operation
- **Age metric.** `age(x) = (x - rob_head_ptr) mod 2^PTR_W`, computed at PTR_W bits with natural wrap. A smaller age means an older instruction.
- **States:** IDLE, PENDING, RAISE, WAIT_RECOVER.
- **IDLE**
  - If `report_valid` and the report survives flush, capture idx/cause/epc and go to PENDING.
  - A report survives if there is no `flush_valid`, or if `age(report_rob_idx) < age(flush_rob_idx)`.
- **PENDING, flush and replacement**
  - If `flush_valid` and `age(held) >= age(flush_rob_idx)`, drop the held exception and go to IDLE.
  - A surviving report in the same cycle is then captured instead, landing in PENDING.
  - Otherwise, a surviving report with `age(report) < age(held)` replaces the held entry.
  - Equal or younger reports are ignored; on an equal index the first report wins.
- **PENDING, raise.** If `rob_head_valid` and `rob_head_ptr == held idx` (and the entry was not dropped this cycle), go to RAISE.
- **RAISE**
  - `exception_occurred` = 1 for exactly this one cycle.
  - If `recover` = 1, go to IDLE; else go to WAIT_RECOVER and clear the timeout counter.
- **WAIT_RECOVER**
  - `recover` = 1 goes to IDLE.
  - Otherwise the counter increments. When it reaches TIMEOUT, set `timeout_err` and go to RAISE (re-pulse), keeping the held data.
- **Ignored inputs.** In RAISE and WAIT_RECOVER, all reports and flushes are ignored; the pipeline is about to be flushed by the handler.
- **retire_block** = (PENDING && `rob_head_valid` && `rob_head_ptr` == held idx) || RAISE || WAIT_RECOVER.
- **Outputs in IDLE.** `exception_pc`, `exception_cause` and `exception_epc` read 0.

## Timing
- **Reset.**
  - State goes to IDLE.
  - `exception_occurred`, `exception_pc`, `exception_cause`, `exception_epc`, `timeout_err`, the held registers and the counter all go to 0.
  - `retire_block` evaluates to 0.
  - Reset mid-operation, including in RAISE or WAIT_RECOVER, aborts immediately with no pulse.
- **Latency.**
  - Report at cycle N, head already equal to the report index: PENDING at N+1, `retire_block` high at N+1, `exception_occurred` at N+2.
  - Head arrives later: the pulse comes 1 cycle after the first cycle PENDING and head match.
- **Recover sampling.**
  - `recover` is sampled in RAISE and WAIT_RECOVER only; it is ignored in IDLE and PENDING.
  - Earliest return to IDLE is the cycle after RAISE.
  - A new report can be captured in the first IDLE cycle.
- **Timeout.** The re-pulse occurs TIMEOUT+1 cycles after the original pulse if `recover` never arrives.
- **Wrap-around.**
  - Age comparison stays correct across index wrap.
  - Example: head=14, held=1 (age 3) is replaced by report 15 (age 1).
- **No extra stall.** `retire_block` is never asserted in IDLE, so an exception-free head retires with no added stall.

## Test plan
- Report idx=5, cause=2, epc=0x100, with head=5 valid, at cycle N -> `retire_block`=1 at N+1; `exception_occurred`=1 at N+2 only, with `exception_pc`=5, cause=2, epc=0x100; `recover` at N+4 -> IDLE at N+5.
- Head=14: report idx=1, then report idx=15 -> held becomes 15. A later report of idx=2 is ignored. When head=15, the pulse carries `exception_pc`=15.
- Held idx=9, head=6, `flush_valid` with `flush_rob_idx`=8 -> state IDLE, no pulse. The same flush with a simultaneous report idx=7 -> held becomes 7.
- Two reports for idx=3 in consecutive cycles with different causes -> the first cause is retained.
- Raise, then `recover` withheld -> second pulse exactly 16 cycles after the first; `timeout_err`=1 and stays 1 after `recover`.
- Assert `reset` during WAIT_RECOVER -> all outputs 0 asynchronously; no pulse after release until a new report arrives.
